// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parameterised up/down counter.
// Optional saturating behaviour is selected with the COUNTER_SATURATE_EN macro.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Full-scale count for a register of the given width.
    // A 32-bit width cannot be built with a shift, so it is handled separately.
    function automatic logic [31:0] default_max_count(input int unsigned width);
        if (width >= 32)
            return 32'hFFFF_FFFF;
        else
            return (32'd1 << width) - 32'd1;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-count, boundary detection and load clamping.
// COUNTER_SATURATE_EN selects hold-at-bound instead of wrap-around.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     MAX_COUNT = WIDTH'(default_max_count(WIDTH))
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count_next,
    output logic             at_bound,
    output logic [WIDTH-1:0] load_value
);

    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        at_bound   = (dir == DIR_UP) ? (q == MAX_COUNT) : (q == '0);
        load_value = (d > MAX_COUNT) ? MAX_COUNT : d;
        count_next = q;

        if (at_bound) begin
`ifdef COUNTER_SATURATE_EN
            count_next = q;
`else
            count_next = (dir == DIR_UP) ? '0 : MAX_COUNT;
`endif
        end else begin
            count_next = (dir == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
        end
    end

endmodule : counter_next

// File: rtl/param_updown_counter.sv
// Up/down counter with parallel load, wrap pulse and sticky overflow flag.
// Define COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     MAX_COUNT = WIDTH'(default_max_count(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_value;
    logic             at_bound;

    counter_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next (
        .q          (q),
        .dir        (dir),
        .d          (d),
        .count_next (count_next),
        .at_bound   (at_bound),
        .load_value (load_value)
    );

    assign tc = en & at_bound;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            q    <= load_value;
            wrap <= 1'b0;
            ovf  <= ovf & ~clr_ovf;
        end else if (en) begin
            q    <= count_next;
            wrap <= at_bound;
            // A boundary hit on the same edge as clr_ovf leaves the flag set.
            ovf  <= at_bound | (ovf & ~clr_ovf);
        end else begin
            wrap <= 1'b0;
            ovf  <= ovf & ~clr_ovf;
        end
    end

endmodule : param_updown_counter

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count register width in bits (2..32).
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1, the highest count value (1..2**WIDTH-1); the count range is 0..MAX_COUNT.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port dir  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port d  input  WIDTH  parallel load value.
REQ-009 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-010 SHALL have port q  output  WIDTH  registered count value.
REQ-011 SHALL have port tc  output  1  terminal count, combinational: en & ((dir & q==MAX_COUNT) | (~dir & q==0)).
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle after a boundary crossing.
REQ-013 SHALL have port ovf  output  1  registered sticky flag, set by any boundary crossing.

Function
REQ-014 Per edge, priority SHALL be: reset low > load > en > hold.
REQ-015 load high SHALL set q to d on the next edge, regardless of en and dir; a d above MAX_COUNT SHALL be clamped to MAX_COUNT.
REQ-016 Load SHALL never assert wrap or set ovf.
REQ-017 With en high and load low, q SHALL increment by 1 (dir=1) or decrement by 1 (dir=0) on each edge; latency from en to a q change is 1 cycle.
REQ-018 Up-count from MAX_COUNT SHALL wrap to 0; down-count from 0 SHALL wrap to MAX_COUNT (non-power-of-two MAX_COUNT honoured).
REQ-019 A wrap SHALL assert wrap for exactly one cycle, the cycle after the edge, and set ovf.
REQ-020 ovf SHALL stay high until clr_ovf is sampled high; if clr_ovf coincides with a new wrap, set SHALL win.
REQ-021 With en low and load low, q, ovf SHALL hold and wrap SHALL be 0.
REQ-022 A dir change SHALL take effect on the same edge it is sampled; there is no turnaround cycle.
REQ-023 All arithmetic SHALL be WIDTH bits, with no carry out beyond the wrap and ovf signals.

Reset
REQ-024 reset low at an edge SHALL force q=0, wrap=0 and ovf=0, overriding load, en and clr_ovf.
REQ-025 Reset asserted mid-count SHALL take effect on the next edge only; there is no asynchronous path.
REQ-026 After reset is released, counting SHALL resume from 0 on the first edge with en high.

Configuration
REQ-027 Macro COUNTER_SATURATE_EN: when defined, the counter SHALL saturate at MAX_COUNT when counting up and at 0 when counting down, instead of wrapping.
REQ-028 With COUNTER_SATURATE_EN defined, a saturation hit (en high at the bound) SHALL pulse wrap and set ovf, and q SHALL hold.
REQ-029 With COUNTER_SATURATE_EN undefined, wrap-around per REQ-018 SHALL apply.
REQ-030 tc SHALL be identical in both builds.

Structure
REQ-031 Package counter_pkg SHALL hold the dir encoding constants (DIR_UP=1, DIR_DOWN=0) and a function computing the default MAX_COUNT from WIDTH.
REQ-032 Sub-module counter_next SHALL be the combinational next-value, boundary and saturation logic, parametrised by WIDTH and MAX_COUNT.
REQ-033 The top level SHALL hold only the registers and priority logic.

Verification
REQ-034 Reset low for 2 cycles with en=1 and load=1 -> q=0, wrap=0, ovf=0 throughout; after release with en=1, dir=1 -> q=1,2,3 on successive edges.
REQ-035 WIDTH=8 default, load d=254, then en=1, dir=1 for 3 cycles -> q=255, 0, 1; tc=1 while q=255; wrap high for one cycle after q=0 appears; ovf stays 1.
REQ-036 MAX_COUNT=9, q=0, en=1, dir=0 -> q=9, 8; wrap pulse and ovf set; load d=12 -> q=9 (clamp).
REQ-037 Same edge: en=1, load=1, d=0x55 -> q=0x55; same edge: clr_ovf=1 and a wrap -> ovf remains 1.
REQ-038 COUNTER_SATURATE_EN defined, q=255, en=1, dir=1 for 3 cycles -> q stays 255, ovf=1, wrap pulses each cycle.
REQ-039 Mid-count reset at q=0x40 -> q=0 on the next edge, and ovf cleared.
